// File: rtl/branch_resolve_ex.sv
// Execute-stage branch resolution with a direct-mapped BTB/BHT predictor.
// Fetch lookup is combinational; training happens on the clock edge for each resolved control op.
module branch_resolve_ex #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   output logic        PredTakenF,
   output logic [31:0] PredTargetF,
   input  logic        BranchE,
   input  logic        JumpE,
   input  logic        jalrE,
   input  logic [2:0]  funct3E,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic [31:0] PCE,
   input  logic [31:0] ImmExtE,
   input  logic        PredTakenE,
   input  logic [31:0] PredTargetE,
   output logic        RedirectE,
   output logic [31:0] RedirectPCE,
   output logic [31:0] BrCount,
   output logic [31:0] MissCount
);
   localparam int N     = 1 << INDEX_BITS;
   localparam int TAG_W = 32 - INDEX_BITS - 2;

   logic [N-1:0]                valid_q, valid_d;
   logic [N-1:0][1:0]           ctr_q, ctr_d;
   logic [N-1:0][TAG_W-1:0]     tag_q, tag_d;
   logic [N-1:0][31:0]          tgt_q, tgt_d;
   logic [31:0]                 br_cnt_q, br_cnt_d;
   logic [31:0]                 miss_cnt_q, miss_cnt_d;

   logic [INDEX_BITS-1:0] idx_f, idx_e;
   logic [TAG_W-1:0]      tag_f, tag_e;
   logic                  hit_f, hit_e;
   logic                  ctl_e, cond_e, taken_e, jmp_e;
   logic [31:0]           target_e;

   assign idx_f = PCF[INDEX_BITS+1:2];
   assign tag_f = PCF[31:INDEX_BITS+2];
   assign idx_e = PCE[INDEX_BITS+1:2];
   assign tag_e = PCE[31:INDEX_BITS+2];

   assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign PredTakenF  = hit_f && ctr_q[idx_f][1];
   assign PredTargetF = hit_f ? tgt_q[idx_f] : 32'd0;

   assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign jmp_e = JumpE | jalrE;
   assign ctl_e = BranchE | jmp_e;

   always_comb begin
      cond_e = 1'b0;
      case (funct3E)
         3'b000:  cond_e = (SrcAE == SrcBE);
         3'b001:  cond_e = (SrcAE != SrcBE);
         3'b100:  cond_e = ($signed(SrcAE) <  $signed(SrcBE));
         3'b101:  cond_e = ($signed(SrcAE) >= $signed(SrcBE));
         3'b110:  cond_e = (SrcAE <  SrcBE);
         3'b111:  cond_e = (SrcAE >= SrcBE);
         default: cond_e = 1'b0;
      endcase
   end

   assign taken_e     = jmp_e | (BranchE & cond_e);
   assign target_e    = jalrE ? ((SrcAE + ImmExtE) & ~32'd1) : (PCE + ImmExtE);
   assign RedirectPCE = taken_e ? target_e : (PCE + 32'd4);
   assign RedirectE   = ctl_e & ((taken_e & (!PredTakenE | (PredTargetE != target_e)))
                                | (!taken_e & PredTakenE));

   always_comb begin
      valid_d = valid_q;
      ctr_d   = ctr_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      if (ctl_e) begin
         if (hit_e) begin
            if (taken_e) begin
               ctr_d[idx_e] = (jmp_e || ctr_q[idx_e] == 2'd3) ? 2'd3 : ctr_q[idx_e] + 2'd1;
               tgt_d[idx_e] = target_e;
            end else if (ctr_q[idx_e] != 2'd0) begin
               ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
            end
         end else if (taken_e) begin
            valid_d[idx_e] = 1'b1;
            tag_d[idx_e]   = tag_e;
            tgt_d[idx_e]   = target_e;
            ctr_d[idx_e]   = jmp_e ? 2'd3 : 2'd2;
         end
      end
   end

   always_comb begin
      br_cnt_d   = (ctl_e && br_cnt_q != 32'hFFFF_FFFF) ? br_cnt_q + 32'd1 : br_cnt_q;
      miss_cnt_d = (RedirectE && miss_cnt_q != 32'hFFFF_FFFF) ? miss_cnt_q + 32'd1 : miss_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q    <= '0;
         ctr_q      <= {N{2'b01}};
         tag_q      <= '0;
         tgt_q      <= '0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         ctr_q      <= ctr_d;
         tag_q      <= tag_d;
         tgt_q      <= tgt_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign BrCount   = br_cnt_q;
   assign MissCount = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolve_ex.sv
// Directed bench for branch_resolve_ex: expected responses are queued when stimulus is driven
// and popped once the combinational outputs have settled.
module tb_branch_resolve_ex;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        BranchE, JumpE, jalrE;
   logic [2:0]  funct3E;
   logic [31:0] SrcAE, SrcBE, PCE, ImmExtE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        RedirectE;
   logic [31:0] RedirectPCE, BrCount, MissCount;

   typedef struct packed {
      logic        bit1;
      logic [31:0] word;
   } exp_t;

   exp_t ex_q[$];
   exp_t lk_q[$];
   int checks = 0;
   int errors = 0;
   int br_m   = 0;
   int miss_m = 0;

   branch_resolve_ex #(.INDEX_BITS(4)) dut (
      .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
      .BranchE(BranchE), .JumpE(JumpE), .jalrE(jalrE), .funct3E(funct3E),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .PCE(PCE), .ImmExtE(ImmExtE),
      .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
      .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
      .BrCount(BrCount), .MissCount(MissCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_ctl();
      BranchE = 1'b0; JumpE = 1'b0; jalrE = 1'b0; funct3E = 3'd0;
      SrcAE = '0; SrcBE = '0; PCE = '0; ImmExtE = '0; PredTakenE = 1'b0; PredTargetE = '0;
   endtask

   // One execute-stage op: check the combinational response, then let exactly one edge train.
   task automatic ex(input string tag, input logic b, input logic j, input logic r,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] bb,
                     input logic [31:0] pc, input logic [31:0] imm,
                     input logic pt, input logic [31:0] ptgt,
                     input logic exp_redir, input logic [31:0] exp_rpc);
      exp_t e;
      @(negedge clk);
      BranchE = b; JumpE = j; jalrE = r; funct3E = f3; SrcAE = a; SrcBE = bb;
      PCE = pc; ImmExtE = imm; PredTakenE = pt; PredTargetE = ptgt;
      ex_q.push_back('{exp_redir, exp_rpc});
      #1;
      e = ex_q.pop_front();
      chk({tag, ".redir"}, {31'd0, RedirectE}, {31'd0, e.bit1});
      chk({tag, ".rpc"}, RedirectPCE, e.word);
      if (b | j | r) begin
         br_m++;
         if (exp_redir) miss_m++;
      end
      @(posedge clk);
      #1;
      clear_ctl();
   endtask

   task automatic look(input string tag, input logic [31:0] pc,
                       input logic exp_pt, input logic [31:0] exp_tgt);
      exp_t e;
      @(negedge clk);
      PCF = pc;
      lk_q.push_back('{exp_pt, exp_tgt});
      #1;
      e = lk_q.pop_front();
      chk({tag, ".pt"}, {31'd0, PredTakenF}, {31'd0, e.bit1});
      chk({tag, ".ptgt"}, PredTargetF, e.word);
   endtask

   task automatic cnt(input string tag);
      chk({tag, ".br"}, BrCount, br_m);
      chk({tag, ".miss"}, MissCount, miss_m);
   endtask

   initial begin
      reset = 1'b1;
      PCF = 32'h100;
      clear_ctl();
      #12;
      chk("rst.pt", {31'd0, PredTakenF}, 32'd0);
      chk("rst.ptgt", PredTargetF, 32'd0);
      cnt("rst");
      @(negedge clk);
      reset = 1'b0;

      // cold miss, taken eq branch
      ex("cold", 1, 0, 0, 3'b000, 5, 5, 32'h100, 32'h20, 0, 0, 1, 32'h120);
      look("cold.lk", 32'h100, 1, 32'h120);
      cnt("cold");

      // correct not-taken: same index, different tag, no allocation
      ex("nt", 1, 0, 0, 3'b001, 7, 7, 32'h200, 32'h40, 0, 0, 0, 32'h204);
      look("nt.lk", 32'h200, 0, 0);
      look("alias.lk", 32'h140, 0, 0);
      look("keep.lk", 32'h100, 1, 32'h120);
      cnt("nt");

      // idle cycle: no redirect, no update
      ex("idle", 0, 0, 0, 3'b000, 1, 2, 32'h100, 32'h8, 1, 32'h120, 0, 32'h104);
      cnt("idle");

      // saturation and retargeting at 0x100
      ex("sat1", 1, 0, 0, 3'b000, 3, 3, 32'h100, 32'h20, 1, 32'h120, 0, 32'h120);
      ex("sat2", 1, 0, 0, 3'b000, 3, 3, 32'h100, 32'h20, 1, 32'h120, 0, 32'h120);
      ex("sat3", 1, 0, 0, 3'b000, 3, 3, 32'h100, 32'h40, 1, 32'h120, 1, 32'h140);
      look("sat3.lk", 32'h100, 1, 32'h140);
      ex("dec1", 1, 0, 0, 3'b000, 1, 2, 32'h100, 32'h40, 1, 32'h140, 1, 32'h104);
      look("dec1.lk", 32'h100, 1, 32'h140);
      ex("dec2", 1, 0, 0, 3'b000, 1, 2, 32'h100, 32'h40, 1, 32'h140, 1, 32'h104);
      look("dec2.lk", 32'h100, 0, 32'h140);
      ex("dec3", 1, 0, 0, 3'b000, 1, 2, 32'h100, 32'h40, 0, 0, 0, 32'h104);
      ex("dec4", 1, 0, 0, 3'b000, 1, 2, 32'h100, 32'h40, 0, 0, 0, 32'h104);
      // counter at 0: one taken update brings it to 1, still predicting not-taken
      ex("inc0", 1, 0, 0, 3'b000, 4, 4, 32'h100, 32'h40, 0, 0, 1, 32'h140);
      look("inc0.lk", 32'h100, 0, 32'h140);
      cnt("sat");

      // jalr target mismatch, allocates index 1 strongly taken
      ex("jalr", 0, 0, 1, 3'b000, 32'h1003, 0, 32'h304, 32'h4, 1, 32'h1004, 1, 32'h1006);
      look("jalr.lk", 32'h304, 1, 32'h1006);

      // jal: cold miss then correctly predicted hit
      ex("jal1", 0, 1, 0, 3'b000, 0, 0, 32'h408, 32'h100, 0, 0, 1, 32'h508);
      ex("jal2", 0, 1, 0, 3'b000, 0, 0, 32'h408, 32'h100, 1, 32'h508, 0, 32'h508);
      look("jal.lk", 32'h408, 1, 32'h508);

      // signed vs unsigned compares with -1 vs 1
      ex("blt", 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1, 32'h50C, 32'h10, 0, 0, 1, 32'h51C);
      ex("bltu", 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 1, 32'h610, 32'h10, 0, 0, 0, 32'h614);
      ex("bge", 1, 0, 0, 3'b101, 32'hFFFF_FFFF, 1, 32'h620, 32'h10, 1, 32'h630, 1, 32'h624);
      ex("bgeu", 1, 0, 0, 3'b111, 32'hFFFF_FFFF, 1, 32'h620, 32'h10, 0, 0, 1, 32'h630);
      ex("f3_010", 1, 0, 0, 3'b010, 9, 9, 32'h640, 32'h10, 0, 0, 0, 32'h644);
      look("blt.lk", 32'h50C, 1, 32'h51C);
      look("bltu.lk", 32'h610, 0, 0);
      cnt("cmp");

      // reset asserted while a taken branch sits in execute
      @(negedge clk);
      BranchE = 1'b1; funct3E = 3'b000; SrcAE = 1; SrcBE = 1; PCE = 32'h714; ImmExtE = 32'h20;
      reset = 1'b1;
      #1;
      br_m = 0; miss_m = 0;
      cnt("midrst");
      @(negedge clk);
      clear_ctl();
      reset = 1'b0;
      look("midrst.lk", 32'h714, 0, 0);
      look("midrst.lk2", 32'h304, 0, 0);
      cnt("postrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
